// File: rtl/dmem_responder.sv
// Word-organised data memory responder for the RV32I load/store port.
// One request at a time, LATENCY wait states, valid/ready response channel.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  initiator has a request        req_ready  responder is IDLE
//   req_we     1 = store, 0 = load            req_addr   byte address
//   req_wdata  store data                     req_mask   store byte enables
//   rsp_valid  response available             rsp_ready  initiator takes response
//   rsp_rdata  load data (0 for stores/errors)
//   rsp_err    misaligned or out-of-range request
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = LATENCY[3:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_mask;

    logic [31:0] mem [DEPTH];

    // The commit edge uses the live request when LATENCY = 0 (commit
    // happens on the acceptance edge), otherwise the latched copy.
    logic          c_we;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic [3:0]    c_mask;
    logic          c_err;
    logic [AW-1:0] c_idx;
    logic          commit;
    logic [31:0]   c_rdata;

    assign req_ready = (state == IDLE) && rst;

    always_comb begin
        c_we    = a_we;
        c_addr  = a_addr;
        c_wdata = a_wdata;
        c_mask  = a_mask;
        if (state == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_mask  = req_mask;
        end
    end

    assign c_err = (c_addr[1:0] != 2'b00) || (|c_addr[31:AW+2]);
    assign c_idx = c_addr[AW+1:2];

    always_comb begin
        commit = 1'b0;
        if (state == WAIT && cnt == 4'd1)
            commit = 1'b1;
        if (state == IDLE && req_valid && req_ready && LATENCY == 0)
            commit = 1'b1;
    end

    always_comb begin
        c_rdata = '0;
        if (!c_we && !c_err)
            c_rdata = mem[c_idx];
    end

    // Array is deliberately not reset; only the commit edge writes it.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_mask[i])
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_we      <= 1'b0;
            a_addr    <= '0;
            a_wdata   <= '0;
            a_mask    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_we    <= req_we;
                        a_addr  <= req_addr;
                        a_wdata <= req_wdata;
                        a_mask  <= req_mask;
                        if (LATENCY == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= c_rdata;
                            rsp_err   <= c_err;
                        end else begin
                            cnt   <= LAT;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= c_rdata;
                        rsp_err   <= c_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
